// File: rtl/ariane_pkg.sv
// Shared core types: functional-unit encoding, the decoded scoreboard entry,
// the issue FIFO depth and the memory-op classifier used for the LSU head hold.
package ariane_pkg;

   localparam int unsigned IssueFifoDepth = 4;

   typedef enum logic [2:0] {
      NONE,
      LOAD,
      STORE,
      ALU,
      CTRL_FLOW,
      MULT,
      CSR
   } fu_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [2:0]  trans_id;
      fu_t         fu;
      logic [6:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        use_imm;
   } scoreboard_entry_t;

   // Loads and stores must wait for the LSU before they may issue.
   function automatic logic is_mem_op(input fu_t fu);
      return (fu == LOAD) || (fu == STORE);
   endfunction

endpackage

// File: rtl/issue_entry_fifo.sv
// Decode->issue buffer: acknowledges decoded entries, queues them in order and
// presents the head to the scoreboard. Holds a memory op at the head until the
// LSU is ready and caps the number of buffered control-flow entries.
// Optional build macro: ISSUE_FIFO_BYPASS_EN (zero-latency presentation when empty).
module issue_entry_fifo
   import ariane_pkg::*;
#(
   parameter int unsigned DEPTH         = IssueFifoDepth,
   parameter int unsigned CTRL_FLOW_MAX = 1
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           flush_i,
   input  scoreboard_entry_t              issue_entry_i,
   input  logic                           issue_entry_valid_i,
   input  logic                           is_ctrl_flow_i,
   output logic                           issue_instr_ack_o,
   output scoreboard_entry_t              issue_entry_o,
   output logic                           issue_entry_valid_o,
   output logic                           is_ctrl_flow_o,
   input  logic                           issue_instr_ack_i,
   input  logic                           lsu_ready_i,
   output logic [$clog2(DEPTH+1)-1:0]     count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
   localparam logic [CW-1:0] CtrlMax = CW'(CTRL_FLOW_MAX);

   scoreboard_entry_t mem_q  [DEPTH];
   logic              ctrl_q [DEPTH];
   logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]     count_q, count_d;
   logic [CW-1:0]     ctrl_cnt_q, ctrl_cnt_d;

   logic              full, empty, ctrl_limit, ack, push, bypass;
   logic              head_valid, head_ctrl, valid, pop;
   logic              write_en, pop_store, ctrl_inc, ctrl_dec;
   scoreboard_entry_t head_entry;

   // Handshake, head selection and occupancy bookkeeping.
   always_comb begin
      full       = (count_q == FullCnt);
      empty      = (count_q == '0);
      ctrl_limit = is_ctrl_flow_i && (ctrl_cnt_q == CtrlMax);
      ack        = !flush_i && !full && !ctrl_limit;
      push       = issue_entry_valid_i && ack;

`ifdef ISSUE_FIFO_BYPASS_EN
      bypass = empty && issue_entry_valid_i && ack;
`else
      bypass = 1'b0;
`endif

      head_valid = 1'b0;
      head_ctrl  = 1'b0;
      head_entry = '0;
      if (!empty) begin
         head_valid = 1'b1;
         head_ctrl  = ctrl_q[rd_ptr_q];
         head_entry = mem_q[rd_ptr_q];
      end else if (bypass) begin
         head_valid = 1'b1;
         head_ctrl  = is_ctrl_flow_i;
         head_entry = issue_entry_i;
      end

      valid = head_valid && !(is_mem_op(head_entry.fu) && !lsu_ready_i) && !flush_i;
      pop   = valid && issue_instr_ack_i;

      // A bypassed entry consumed in its arrival cycle never touches storage.
      pop_store = pop && !empty;
      write_en  = push && !(bypass && pop);

      count_d = count_q;
      if (write_en && !pop_store) begin
         count_d = count_q + CW'(1);
      end else if (!write_en && pop_store) begin
         count_d = count_q - CW'(1);
      end

      ctrl_inc   = write_en && is_ctrl_flow_i;
      ctrl_dec   = pop_store && ctrl_q[rd_ptr_q];
      ctrl_cnt_d = ctrl_cnt_q;
      if (ctrl_inc && !ctrl_dec) begin
         ctrl_cnt_d = ctrl_cnt_q + CW'(1);
      end else if (!ctrl_inc && ctrl_dec) begin
         ctrl_cnt_d = ctrl_cnt_q - CW'(1);
      end

      issue_instr_ack_o   = ack;
      issue_entry_o       = head_entry;
      issue_entry_valid_o = valid;
      is_ctrl_flow_o      = head_ctrl;
      count_o             = count_q;
   end

   // Storage, pointers and counters; flush discards everything held.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i]  <= '0;
            ctrl_q[i] <= 1'b0;
         end
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         ctrl_cnt_q <= '0;
      end else if (flush_i) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         ctrl_cnt_q <= '0;
      end else begin
         if (write_en) begin
            mem_q[wr_ptr_q]  <= issue_entry_i;
            ctrl_q[wr_ptr_q] <= is_ctrl_flow_i;
            wr_ptr_q         <= wr_ptr_q + PW'(1);
         end
         if (pop_store) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         count_q    <= count_d;
         ctrl_cnt_q <= ctrl_cnt_d;
      end
   end

endmodule

// File: tb/tb_issue_entry_fifo.sv
// Directed self-checking bench for issue_entry_fifo (DEPTH=4, CTRL_FLOW_MAX=1).
module tb_issue_entry_fifo;
   import ariane_pkg::*;

   logic              clk_i;
   logic              rst_ni;
   logic              flush_i;
   scoreboard_entry_t issue_entry_i;
   logic              issue_entry_valid_i;
   logic              is_ctrl_flow_i;
   logic              issue_instr_ack_o;
   scoreboard_entry_t issue_entry_o;
   logic              issue_entry_valid_o;
   logic              is_ctrl_flow_o;
   logic              issue_instr_ack_i;
   logic              lsu_ready_i;
   logic [2:0]        count_o;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   issue_entry_fifo #(
      .DEPTH         (4),
      .CTRL_FLOW_MAX (1)
   ) dut (
      .clk_i               (clk_i),
      .rst_ni              (rst_ni),
      .flush_i             (flush_i),
      .issue_entry_i       (issue_entry_i),
      .issue_entry_valid_i (issue_entry_valid_i),
      .is_ctrl_flow_i      (is_ctrl_flow_i),
      .issue_instr_ack_o   (issue_instr_ack_o),
      .issue_entry_o       (issue_entry_o),
      .issue_entry_valid_o (issue_entry_valid_o),
      .is_ctrl_flow_o      (is_ctrl_flow_o),
      .issue_instr_ack_i   (issue_instr_ack_i),
      .lsu_ready_i         (lsu_ready_i),
      .count_o             (count_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic offer(input fu_t fu, input logic [31:0] pc, input logic ctrl);
      issue_entry_i       = '0;
      issue_entry_i.pc    = pc;
      issue_entry_i.fu    = fu;
      issue_entry_valid_i = 1'b1;
      is_ctrl_flow_i      = ctrl;
   endtask

   task automatic idle();
      issue_entry_valid_i = 1'b0;
      is_ctrl_flow_i      = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_ni              = 1'b0;
      flush_i             = 1'b0;
      issue_entry_i       = '0;
      issue_entry_valid_i = 1'b0;
      is_ctrl_flow_i      = 1'b0;
      issue_instr_ack_i   = 1'b0;
      lsu_ready_i         = 1'b1;

      // Reset state
      repeat (2) @(negedge clk_i);
      #1;
      check_eq("rst_ack",   32'(issue_instr_ack_o),   32'd1);
      check_eq("rst_valid", 32'(issue_entry_valid_o), 32'd0);
      check_eq("rst_count", 32'(count_o),             32'd0);
      check_eq("rst_pc",    issue_entry_o.pc,         32'd0);
      check_eq("rst_ctrl",  32'(is_ctrl_flow_o),      32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // 1: single ALU entry, consumer always ready
      @(negedge clk_i);
      offer(ALU, 32'h100, 1'b0);
      issue_instr_ack_i = 1'b1;
      #1;
      check_eq("t1_ack", 32'(issue_instr_ack_o), 32'd1);
`ifdef ISSUE_FIFO_BYPASS_EN
      check_eq("t1_valid_n", 32'(issue_entry_valid_o), 32'd1);
      check_eq("t1_pc_n",    issue_entry_o.pc,         32'h100);
      @(negedge clk_i);
      idle();
      #1;
      check_eq("t1_count_end", 32'(count_o), 32'd0);
`else
      check_eq("t1_valid_n", 32'(issue_entry_valid_o), 32'd0);
      @(negedge clk_i);
      idle();
      #1;
      check_eq("t1_valid_n1", 32'(issue_entry_valid_o), 32'd1);
      check_eq("t1_pc_n1",    issue_entry_o.pc,         32'h100);
      check_eq("t1_count_n1", 32'(count_o),             32'd1);
      @(negedge clk_i);
      #1;
      check_eq("t1_count_end", 32'(count_o),             32'd0);
      check_eq("t1_valid_end", 32'(issue_entry_valid_o), 32'd0);
`endif

      // 2: fill to full, then a 5th waits until the cycle after the first pop
      issue_instr_ack_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         offer(ALU, 32'h200 + 32'(i), 1'b0);
         #1;
         check_eq("t2_fill_ack", 32'(issue_instr_ack_o), 32'd1);
      end
      @(negedge clk_i);
      offer(ALU, 32'h204, 1'b0);
      issue_instr_ack_i = 1'b1;
      #1;
      check_eq("t2_full_count", 32'(count_o),             32'd4);
      check_eq("t2_full_ack",   32'(issue_instr_ack_o),   32'd0);
      check_eq("t2_full_valid", 32'(issue_entry_valid_o), 32'd1);
      check_eq("t2_full_head",  issue_entry_o.pc,         32'h200);
      @(negedge clk_i);
      #1;
      check_eq("t2_after_pop_count", 32'(count_o),           32'd3);
      check_eq("t2_after_pop_ack",   32'(issue_instr_ack_o), 32'd1);
      check_eq("t2_after_pop_head",  issue_entry_o.pc,       32'h201);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         if (i == 0) idle();
         #1;
         check_eq("t2_drain_head",  issue_entry_o.pc,         32'h202 + 32'(i));
         check_eq("t2_drain_valid", 32'(issue_entry_valid_o), 32'd1);
      end
      @(negedge clk_i);
      issue_instr_ack_i = 1'b0;
      #1;
      check_eq("t2_end_count", 32'(count_o), 32'd0);

      // 3: LOAD held at head while LSU not ready
      lsu_ready_i       = 1'b0;
      issue_instr_ack_i = 1'b1;
      @(negedge clk_i);
      offer(LOAD, 32'h300, 1'b0);
      @(negedge clk_i);
      idle();
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk_i);
         #1;
         check_eq("t3_hold_valid", 32'(issue_entry_valid_o), 32'd0);
         check_eq("t3_hold_pc",    issue_entry_o.pc,         32'h300);
         check_eq("t3_hold_fu",    32'(issue_entry_o.fu),    32'(LOAD));
         check_eq("t3_hold_count", 32'(count_o),             32'd1);
      end
      @(negedge clk_i);
      lsu_ready_i = 1'b1;
      #1;
      check_eq("t3_rel_valid", 32'(issue_entry_valid_o), 32'd1);
      check_eq("t3_rel_pc",    issue_entry_o.pc,         32'h300);
      @(negedge clk_i);
      #1;
      check_eq("t3_rel_count", 32'(count_o), 32'd0);

      // 4: control-flow cap of one buffered branch
      issue_instr_ack_i = 1'b0;
      @(negedge clk_i);
      offer(CTRL_FLOW, 32'h400, 1'b1);
      #1;
      check_eq("t4_br1_ack", 32'(issue_instr_ack_o), 32'd1);
      @(negedge clk_i);
      offer(CTRL_FLOW, 32'h401, 1'b1);
      #1;
      check_eq("t4_br2_ack",  32'(issue_instr_ack_o), 32'd0);
      check_eq("t4_head_ctrl", 32'(is_ctrl_flow_o),   32'd1);
      offer(ALU, 32'h402, 1'b0);
      #1;
      check_eq("t4_alu_ack", 32'(issue_instr_ack_o), 32'd1);
      @(negedge clk_i);
      offer(CTRL_FLOW, 32'h401, 1'b1);
      issue_instr_ack_i = 1'b1;
      #1;
      check_eq("t4_br2_ack_popcyc", 32'(issue_instr_ack_o), 32'd0);
      check_eq("t4_br1_head",       issue_entry_o.pc,       32'h400);
      @(negedge clk_i);
      issue_instr_ack_i = 1'b0;
      #1;
      check_eq("t4_br2_ack_after", 32'(issue_instr_ack_o), 32'd1);
      check_eq("t4_alu_head",      issue_entry_o.pc,       32'h402);
      @(negedge clk_i);
      idle();
      issue_instr_ack_i = 1'b1;
      #1;
      check_eq("t4_count2",    32'(count_o),        32'd2);
      check_eq("t4_alu_ctrl",  32'(is_ctrl_flow_o), 32'd0);
      @(negedge clk_i);
      #1;
      check_eq("t4_br2_head", issue_entry_o.pc,       32'h401);
      check_eq("t4_br2_ctrl", 32'(is_ctrl_flow_o),    32'd1);
      @(negedge clk_i);
      issue_instr_ack_i = 1'b0;
      #1;
      check_eq("t4_end_count", 32'(count_o), 32'd0);

      // 5: flush with three held (one a branch) and a new entry offered
      @(negedge clk_i);
      offer(ALU, 32'h500, 1'b0);
      @(negedge clk_i);
      offer(CTRL_FLOW, 32'h501, 1'b1);
      @(negedge clk_i);
      offer(ALU, 32'h502, 1'b0);
      @(negedge clk_i);
      offer(ALU, 32'h503, 1'b0);
      flush_i = 1'b1;
      #1;
      check_eq("t5_pre_count", 32'(count_o),             32'd3);
      check_eq("t5_fl_ack",    32'(issue_instr_ack_o),   32'd0);
      check_eq("t5_fl_valid",  32'(issue_entry_valid_o), 32'd0);
      @(negedge clk_i);
      flush_i = 1'b0;
      idle();
      #1;
      check_eq("t5_post_count", 32'(count_o),             32'd0);
      check_eq("t5_post_valid", 32'(issue_entry_valid_o), 32'd0);
      offer(CTRL_FLOW, 32'h5F0, 1'b1);
      #1;
      check_eq("t5_ctrl_cleared_ack", 32'(issue_instr_ack_o), 32'd1);
      @(negedge clk_i);
      idle();
      #1;
      check_eq("t5_new_head",  issue_entry_o.pc,  32'h5F0);
      check_eq("t5_new_count", 32'(count_o),      32'd1);
      issue_instr_ack_i = 1'b1;
      @(negedge clk_i);
      issue_instr_ack_i = 1'b0;
      #1;
      check_eq("t5_end_count", 32'(count_o), 32'd0);

      // 6: streaming push/pop of 10 entries, pointers wrap twice
      issue_instr_ack_i = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         @(negedge clk_i);
         if (i < 10) offer(ALU, 32'h600 + 32'(i), 1'b0);
         else idle();
         #1;
         if (i > 0) begin
            check_eq("t6_count", 32'(count_o),             32'd1);
            check_eq("t6_head",  issue_entry_o.pc,         32'h600 + 32'(i - 1));
            check_eq("t6_valid", 32'(issue_entry_valid_o), 32'd1);
         end
         if (i < 10) check_eq("t6_ack", 32'(issue_instr_ack_o), 32'd1);
      end
      @(negedge clk_i);
      issue_instr_ack_i = 1'b0;
      #1;
      check_eq("t6_end_count", 32'(count_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
